cmul_mul_sched: RTL and testbench

//  Sequencer that computes one complex product (twiddle multiply for the FFT butterfly) on a single shared

---
 rtl/cmul_mul_sched.sv | 205 ++++++++++++++++++++
 tb/tb_cmul_mul_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmul_mul_sched
// Brief    : Complex multiply (pr + j*pi) = (ar + j*ai) * (br + j*bi) computed
//            on one shared multi-cycle signed multiplier.
// Revision : 1.0  initial release
// ============================================================================

module cmul_mul_sched #(
    parameter int WIDTH       = 8,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   ar,
    input  logic signed [WIDTH-1:0]   ai,
    input  logic signed [WIDTH-1:0]   br,
    input  logic signed [WIDTH-1:0]   bi,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH:0]   pr,
    output logic signed [2*WIDTH:0]   pi,
    output logic                      mul_start,
    output logic signed [WIDTH-1:0]   mul_a,
    output logic signed [WIDTH-1:0]   mul_b,
    input  logic                      mul_done,
    input  logic signed [2*WIDTH-1:0] mul_product,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int            PW       = 2*WIDTH + 1;
    localparam int            TW       = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MUL_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q,  state_d;
    logic signed [WIDTH-1:0] ar_q,     ar_d;
    logic signed [WIDTH-1:0] ai_q,     ai_d;
    logic signed [WIDTH-1:0] br_q,     br_d;
    logic signed [WIDTH-1:0] bi_q,     bi_d;
    logic signed [WIDTH-1:0] mul_a_q,  mul_a_d;
    logic signed [WIDTH-1:0] mul_b_q,  mul_b_d;
    logic signed [PW-1:0]    acc_re_q, acc_re_d;
    logic signed [PW-1:0]    acc_im_q, acc_im_d;
    logic signed [PW-1:0]    pr_q,     pr_d;
    logic signed [PW-1:0]    pi_q,     pi_d;
    logic [1:0]              idx_q,    idx_d;
    logic [TW-1:0]           tcnt_q,   tcnt_d;
    logic                    err_q,    err_d;

    logic signed [PW-1:0]    w_p_ext;
    logic [1:0]              w_nidx;
    logic signed [WIDTH-1:0] w_sel_a;
    logic signed [WIDTH-1:0] w_sel_b;
    logic                    w_tmo;

    assign w_p_ext = {mul_product[2*WIDTH-1], mul_product};
    assign w_nidx  = idx_q + 2'd1;
    assign w_tmo   = (MUL_TIMEOUT != 0) && (tcnt_q == TMO_LAST);

    // Product order: ar*br, ai*bi, ar*bi, ai*br
    always_comb begin
        w_sel_a = ar_q;
        w_sel_b = br_q;
        case (w_nidx)
            2'd0:    begin w_sel_a = ar_q; w_sel_b = br_q; end
            2'd1:    begin w_sel_a = ai_q; w_sel_b = bi_q; end
            2'd2:    begin w_sel_a = ar_q; w_sel_b = bi_q; end
            default: begin w_sel_a = ai_q; w_sel_b = br_q; end
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    state_d = (idx_q == 2'd3) ? S_DONE : S_ISSUE;
                end else if (w_tmo) begin
                    state_d = S_IDLE;
                end
            end
            default: if (out_ready) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        mul_start = (state_q == S_ISSUE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    always_comb begin
        ar_d     = ar_q;
        ai_d     = ai_q;
        br_d     = br_q;
        bi_d     = bi_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        pr_d     = pr_q;
        pi_d     = pi_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ar_d     = ar;
                    ai_d     = ai;
                    br_d     = br;
                    bi_d     = bi;
                    mul_a_d  = ar;
                    mul_b_d  = br;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    idx_d    = 2'd0;
                end
            end
            S_ISSUE: tcnt_d = '0;
            S_WAIT: begin
                if (mul_done) begin
                    case (idx_q)
                        2'd0:    acc_re_d = acc_re_q + w_p_ext;
                        2'd1:    acc_re_d = acc_re_q - w_p_ext;
                        default: acc_im_d = acc_im_q + w_p_ext;
                    endcase
                    if (idx_q == 2'd3) begin
                        pr_d = acc_re_q;
                        pi_d = acc_im_q + w_p_ext;
                    end else begin
                        idx_d   = w_nidx;
                        mul_a_d = w_sel_a;
                        mul_b_d = w_sel_b;
                    end
                end else if (w_tmo) begin
                    err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            pr_q     <= '0;
            pi_q     <= '0;
            idx_q    <= 2'd0;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            br_q     <= br_d;
            bi_q     <= bi_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            pr_q     <= pr_d;
            pi_q     <= pi_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign pr          = pr_q;
    assign pi          = pi_q;
    assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cmul_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmul_mul_sched
// Brief    : Scoreboard bench for cmul_mul_sched with a variable-latency
//            multiplier responder.
// Revision : 1.0  initial release
// ============================================================================

module tb_cmul_mul_sched;

    localparam int W   = 8;
    localparam int TMO = 64;

    logic                    clkin       = 1'b0;
    logic                    rst_n       = 1'b0;
    logic                    in_valid    = 1'b0;
    logic                    in_ready;
    logic signed [W-1:0]     ar          = '0;
    logic signed [W-1:0]     ai          = '0;
    logic signed [W-1:0]     br          = '0;
    logic signed [W-1:0]     bi          = '0;
    logic                    out_valid;
    logic                    out_ready   = 1'b0;
    logic signed [2*W:0]     pr;
    logic signed [2*W:0]     pi;
    logic                    mul_start;
    logic signed [W-1:0]     mul_a;
    logic signed [W-1:0]     mul_b;
    logic                    mul_done    = 1'b0;
    logic signed [2*W-1:0]   mul_product = '0;
    logic                    busy;
    logic                    err_timeout;

    cmul_mul_sched #(.WIDTH(W), .MUL_TIMEOUT(TMO)) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ar          (ar),
        .ai          (ai),
        .br          (br),
        .bi          (bi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pr          (pr),
        .pi          (pi),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct { int re; int im; int acc_cyc; int lat; } exp_t;
    typedef struct { int a; int b; } pair_t;
    exp_t  sbq[$];
    pair_t mulq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Multiplier responder: done arrives L cycles after the start cycle.
    int                  cur_L  = 1;
    bit                  noresp = 1'b0;
    bit                  spur   = 1'b0;
    bit                  pending = 1'b0;
    bit                  prev_start = 1'b0;
    int                  mcnt = 0;
    int                  n_start = 0;
    int                  n_done = 0;
    int                  last_start_cyc = 0;
    logic signed [W-1:0] la = '0;
    logic signed [W-1:0] lb = '0;

    always @(negedge clkin) begin : mul_model
        pair_t p;
        mul_done = 1'b0;
        if (pending) begin
            if (busy) begin
                chk("mul_a_held", longint'(mul_a), longint'(la));
                chk("mul_b_held", longint'(mul_b), longint'(lb));
            end
            mcnt--;
            if (mcnt == 0) begin
                mul_done    = 1'b1;
                mul_product = la * lb;
                pending     = 1'b0;
                n_done++;
            end
        end
        if (mul_start) begin
            chk("mul_start_back_to_back", longint'(prev_start), 0);
            chk("mul_start_while_pending", longint'(pending), 0);
            if (mulq.size() == 0) begin
                fail("unexpected_mul_start");
            end else begin
                p = mulq.pop_front();
                chk("mul_a_operand", longint'(mul_a), longint'(p.a));
                chk("mul_b_operand", longint'(mul_b), longint'(p.b));
            end
            n_start++;
            last_start_cyc = cyc;
            if (!noresp) begin
                pending = 1'b1;
                mcnt    = cur_L;
                la      = mul_a;
                lb      = mul_b;
            end
        end
        prev_start = mul_start;
        if (spur && !mul_done && (!pending || mul_start) && ($urandom_range(0, 5) == 0)) begin
            mul_done    = 1'b1;
            mul_product = 16'($urandom);
        end
    end

    int rdy_mode = 2;  // 0 random, 1 held low, 2 held high
    always @(negedge clkin) begin
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    bit                  ov_prev = 1'b0;
    logic signed [2*W:0] pr_h = '0;
    logic signed [2*W:0] pi_h = '0;

    always @(negedge clkin) begin : monitor
        exp_t e;
        #1;
        if (out_valid) begin
            if (!ov_prev) begin
                if (sbq.size() == 0) fail("unexpected_out_valid");
                else chk("out_latency", longint'(cyc - sbq[0].acc_cyc), longint'(sbq[0].lat));
            end else begin
                chk("pr_stable", longint'(pr), longint'(pr_h));
                chk("pi_stable", longint'(pi), longint'(pi_h));
            end
            chk("in_ready_while_out_valid", longint'(in_ready), 0);
            chk("mul_start_while_out_valid", longint'(mul_start), 0);
            if (out_ready && sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("pr", longint'(pr), longint'(e.re));
                chk("pi", longint'(pi), longint'(e.im));
            end
        end
        ov_prev = out_valid;
        pr_h    = pr;
        pi_h    = pi;
    end

    int n_exp = 0;
    int last_acc_cyc = 0;

    task automatic submit(input int a_r, input int a_i, input int b_r, input int b_i,
                          input int L, input bit expect_res);
        int t = 0;
        @(negedge clkin);
        while (!in_ready && t < 2000) begin
            @(negedge clkin);
            t++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            return;
        end
        ar       = W'(a_r);
        ai       = W'(a_i);
        br       = W'(b_r);
        bi       = W'(b_i);
        cur_L    = L;
        in_valid = 1'b1;
        mulq.push_back('{a_r, b_r});
        mulq.push_back('{a_i, b_i});
        mulq.push_back('{a_r, b_i});
        mulq.push_back('{a_i, b_r});
        if (expect_res) begin
            sbq.push_back('{a_r*b_r - a_i*b_i, a_r*b_i + a_i*b_r, cyc, 4*(L+1)+1});
            n_exp++;
        end
        last_acc_cyc = cyc;
        @(negedge clkin);
        in_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int maxc);
        int t = 0;
        while ((sbq.size() != 0 || busy || pending) && t < maxc) begin
            @(negedge clkin);
            #1;
            t++;
        end
        if (sbq.size() != 0 || busy || pending) fail("wait_quiet_timeout");
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},    longint'(in_ready), 1);
        chk({tag, "_out_valid"},   longint'(out_valid), 0);
        chk({tag, "_mul_start"},   longint'(mul_start), 0);
        chk({tag, "_busy"},        longint'(busy), 0);
        chk({tag, "_err_timeout"}, longint'(err_timeout), 0);
        chk({tag, "_pr"},          longint'(pr), 0);
        chk({tag, "_pi"},          longint'(pi), 0);
        chk({tag, "_mul_a"},       longint'(mul_a), 0);
        chk({tag, "_mul_b"},       longint'(mul_b), 0);
    endtask

    initial begin : watchdog
        #1500000;
        fail("global_watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s0;
        int t;
        int c0;
        repeat (3) @(negedge clkin);
        #1;
        chk_reset_values("reset");
        rst_n = 1'b1;

        // (3+4j)*(2-1j), L=3
        s0 = n_start;
        submit(3, 4, 2, -1, 3, 1'b1);
        wait_quiet(500);
        chk("t1_start_pulses", longint'(n_start - s0), 4);

        // full-scale corner and mixed-sign extreme, L=1
        submit(-128, -128, -128, -128, 1, 1'b1);
        submit(127, 0, -128, 0, 1, 1'b1);
        wait_quiet(500);

        // backpressure for 10 cycles, then back-to-back acceptance
        rdy_mode = 1;
        submit(rnd8(), rnd8(), rnd8(), rnd8(), 2, 1'b1);
        t = 0;
        while (!out_valid && t < 500) begin
            @(negedge clkin);
            #1;
            t++;
        end
        if (!out_valid) fail("t3_out_valid_never_rose");
        repeat (10) begin
            @(negedge clkin);
            #1;
            chk("t3_out_valid_held", longint'(out_valid), 1);
            chk("t3_busy_held", longint'(busy), 1);
        end
        c0 = cyc;
        rdy_mode = 2;
        submit(rnd8(), rnd8(), rnd8(), rnd8(), 2, 1'b1);
        chk("t3_accept_after_release", longint'(last_acc_cyc), longint'(c0 + 2));
        wait_quiet(500);

        // multiplier never answers: abort after TMO wait cycles
        noresp = 1'b1;
        submit(5, 6, 7, 8, 1, 1'b0);
        t = 0;
        while (!err_timeout && t < 300) begin
            @(negedge clkin);
            #1;
            t++;
        end
        chk("t4_err_timeout", longint'(err_timeout), 1);
        chk("t4_timeout_cycles", longint'(cyc - last_start_cyc), longint'(TMO + 1));
        chk("t4_in_ready", longint'(in_ready), 1);
        noresp = 1'b0;
        mulq.delete();
        submit(rnd8(), rnd8(), rnd8(), rnd8(), 2, 1'b1);
        wait_quiet(500);
        chk("t4_err_sticky", longint'(err_timeout), 1);

        // asynchronous reset during the third WAIT
        s0 = n_start;
        submit(rnd8(), rnd8(), rnd8(), rnd8(), 10, 1'b0);
        t = 0;
        while (n_start < s0 + 3 && t < 500) begin
            @(negedge clkin);
            #1;
            t++;
        end
        @(negedge clkin);
        #1;
        chk("t5_busy_before_reset", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("t5_async");
        repeat (2) @(negedge clkin);
        rst_n = 1'b1;
        mulq.delete();
        repeat (15) @(negedge clkin);
        #1;
        chk("t5_idle_after_stale_done", longint'(busy), 0);
        submit(rnd8(), rnd8(), rnd8(), rnd8(), 4, 1'b1);
        wait_quiet(500);

        // random traffic with spurious dones and random backpressure
        spur     = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clkin);
            submit(rnd8(), rnd8(), rnd8(), rnd8(), int'($urandom_range(1, 20)), 1'b1);
        end
        wait_quiet(5000);
        spur = 1'b0;

        // every start belongs to a completed op, except 1 timed-out and 3 reset-aborted
        chk("total_start_pulses", longint'(n_start), longint'(4 * n_exp + 4));
        chk("total_real_dones", longint'(n_done), longint'(n_start - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
